// File: rtl/dino_pkg.sv
// ---------------------------------------------------------------------------
// dino_pkg
// Shared constants and types for the obstacle sprite ROM arbiter.
//   DEF_ADDR_W  : default ROM address width, {obstacle type[2:0], row[2:0]}
//   DEF_ROM_LAT : default ROM read latency in clk cycles (legal 1..2)
//   obs_id_t    : requester identifier (OBS0 = obstacle 1, OBS1 = obstacle 2)
//   tag_t       : one entry of the in-flight read tag pipeline
// ---------------------------------------------------------------------------
package dino_pkg;

  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_ROM_LAT = 1;

  typedef enum logic {
    OBS0 = 1'b0,
    OBS1 = 1'b1
  } obs_id_t;

  typedef struct packed {
    logic    valid;
    obs_id_t id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter with a registered priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_req[1:0] : request per requester
//   i_block    : frame start; suppresses grants and resets the pointer
//   o_gnt[1:0] : one-hot grant, combinational
//   o_ptr      : current priority pointer (requester favoured on a tie)
// ---------------------------------------------------------------------------
module rr_arbiter2
  import dino_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_block,
  output logic [1:0] o_gnt,
  output obs_id_t    o_ptr
);

  obs_id_t    ptr_q;
  obs_id_t    ptr_d;
  logic [1:0] gnt;

  // Grant path is gated by rst_n itself so nothing is granted while the
  // block is held in reset.
  always_comb begin
    gnt = 2'b00;
    if (rst_n && !i_block) begin
      case (i_req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (ptr_q == OBS1) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // A grant is only ever issued to an active request, so any grant is a
  // transfer and the pointer moves to the other requester.
  always_comb begin
    ptr_d = ptr_q;
    if (i_block) begin
      ptr_d = OBS0;
    end else if (gnt[0]) begin
      ptr_d = OBS1;
    end else if (gnt[1]) begin
      ptr_d = OBS0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= OBS0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_gnt = gnt;
  assign o_ptr = ptr_q;

endmodule

// File: rtl/obs_rom_arbiter.sv
// ---------------------------------------------------------------------------
// obs_rom_arbiter
// Shares one sprite ROM between two obstacle renderers. Round-robin grant,
// tag pipeline matching the fixed ROM latency, per-requester pixel hold
// registers and a merged obstacle colour output.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_frame_start     : frame start pulse; blocks grants, squashes in-flight
//                       reads, clears hold registers
//   i_req, i_addr0/1  : read requests and addresses from the two renderers
//   o_gnt             : one-hot grant (combinational)
//   o_rom_en/o_rom_addr : ROM read strobe and address (combinational)
//   i_rom_data        : ROM pixel, valid ROM_LAT cycles after o_rom_en
//   o_rsp_valid/o_rsp_data : per-requester return pulse and pixel
//   o_color_obs       : registered OR of the two hold registers
// ROM_LAT must be 1 or 2.
// ---------------------------------------------------------------------------
module obs_rom_arbiter
  import dino_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_frame_start,
  input  logic [1:0]        i_req,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  output logic [1:0]        o_gnt,
  output logic              o_rom_en,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic              i_rom_data,
  output logic [1:0]        o_rsp_valid,
  output logic              o_rsp_data,
  output logic              o_color_obs
);

  logic [1:0] gnt;
  obs_id_t    ptr_unused;

  tag_t       tag_q [ROM_LAT];
  tag_t       tag_d [ROM_LAT];
  tag_t       tag_out;
  logic       rsp_fire;
  logic [1:0] rsp_valid;
  logic [1:0] hold_q;
  logic [1:0] hold_d;
  logic       color_q;
  logic       color_d;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (i_req),
    .i_block (i_frame_start),
    .o_gnt   (gnt),
    .o_ptr   (ptr_unused)
  );

  assign o_gnt      = gnt;
  assign o_rom_en   = |gnt;
  assign o_rom_addr = gnt[1] ? i_addr1 : (gnt[0] ? i_addr0 : '0);

  // Tag shift register: stage 0 records this cycle's transfer, the last
  // stage lines up with the ROM data. Frame start wipes every stage.
  always_comb begin
    for (int i = 0; i < ROM_LAT; i++) begin
      tag_d[i] = '0;
    end
    if (!i_frame_start) begin
      tag_d[0].valid = |gnt;
      tag_d[0].id    = gnt[1] ? OBS1 : OBS0;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // A read landing in the frame-start cycle is squashed too, so a read
  // issued in the previous frame can never leak into the new one.
  assign tag_out   = tag_q[ROM_LAT-1];
  assign rsp_fire  = tag_out.valid && !i_frame_start;
  assign rsp_valid = rsp_fire ? ((tag_out.id == OBS1) ? 2'b10 : 2'b01) : 2'b00;

  assign o_rsp_valid = rsp_valid;
  assign o_rsp_data  = rsp_fire & i_rom_data;

  // Colour is computed from the next hold values so o_color_obs tracks the
  // hold registers directly rather than lagging them by a cycle.
  always_comb begin
    hold_d = hold_q;
    if (i_frame_start) begin
      hold_d = 2'b00;
    end else begin
      if (rsp_valid[0]) hold_d[0] = i_rom_data;
      if (rsp_valid[1]) hold_d[1] = i_rom_data;
    end
    color_d = |hold_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= 2'b00;
      color_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      color_q <= color_d;
    end
  end

  assign o_color_obs = color_q;

endmodule

// File: tb/tb_obs_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_obs_rom_arbiter
// Directed bench for obs_rom_arbiter. Two instances share the request inputs:
// u_dut1 with ROM_LAT = 1 and u_dut2 with ROM_LAT = 2, each fed by its own
// ROM model whose pixel is the address LSB.
// ---------------------------------------------------------------------------
module tb_obs_rom_arbiter;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fs;
  logic [1:0]    req;
  logic [AW-1:0] a0, a1;

  logic [1:0]    gnt1, gnt2, rv1, rv2;
  logic          en1, en2, rd1, rd2, col1, col2;
  logic [AW-1:0] addr1, addr2;
  logic          rom1, rom2, rom2_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obs_rom_arbiter #(.ADDR_W(AW), .ROM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_frame_start(fs), .i_req(req),
    .i_addr0(a0), .i_addr1(a1), .o_gnt(gnt1), .o_rom_en(en1),
    .o_rom_addr(addr1), .i_rom_data(rom1), .o_rsp_valid(rv1),
    .o_rsp_data(rd1), .o_color_obs(col1)
  );

  obs_rom_arbiter #(.ADDR_W(AW), .ROM_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_frame_start(fs), .i_req(req),
    .i_addr0(a0), .i_addr1(a1), .o_gnt(gnt2), .o_rom_en(en2),
    .o_rom_addr(addr2), .i_rom_data(rom2), .o_rsp_valid(rv2),
    .o_rsp_data(rd2), .o_color_obs(col2)
  );

  // ROM models: pixel = address bit 0, returned after the fixed latency.
  always @(posedge clk) begin
    rom1   <= en1 ? addr1[0] : 1'b0;
    rom2_s <= en2 ? addr2[0] : 1'b0;
    rom2   <= rom2_s;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fs = 1'b0; req = 2'b00;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fs = 1'b0; req = 2'b11; a0 = 6'h0B; a1 = 6'h03;
    @(negedge clk);
    checks++; if ({gnt1, en1, addr1} !== '0) begin errors++; $display("FAIL reset_grant1 got gnt=%b en=%b addr=%h exp 0", gnt1, en1, addr1); end
    checks++; if ({gnt2, en2, addr2} !== '0) begin errors++; $display("FAIL reset_grant2 got gnt=%b en=%b addr=%h exp 0", gnt2, en2, addr2); end
    checks++; if ({rv1, rd1, col1, rv2, rd2, col2} !== '0) begin errors++; $display("FAIL reset_rsp got %b exp 0", {rv1, rd1, col1, rv2, rd2, col2}); end
    step();
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    req = 2'b01; a0 = 6'h0B;
    @(negedge clk);
    checks++; if (gnt1 !== 2'b01) begin errors++; $display("FAIL single_gnt got %b exp 01", gnt1); end
    checks++; if (addr1 !== 6'h0B || en1 !== 1'b1) begin errors++; $display("FAIL single_addr got en=%b addr=%h exp en=1 addr=0b", en1, addr1); end
    step();
    req = 2'b00;
    @(negedge clk);
    checks++; if (rv1 !== 2'b01 || rd1 !== 1'b1) begin errors++; $display("FAIL single_rsp got v=%b d=%b exp v=01 d=1", rv1, rd1); end
    checks++; if (gnt1 !== 2'b00 || addr1 !== 6'h00) begin errors++; $display("FAIL single_idle got gnt=%b addr=%h exp 00/00", gnt1, addr1); end
    step();
    $display("test_single done");
  endtask

  task automatic test_alternate();
    logic [1:0] eg, e1, e2;
    do_reset();
    a0 = 6'h01; a1 = 6'h02;
    for (int k = 0; k < 9; k++) begin
      req = (k < 6) ? 2'b11 : 2'b00;
      eg  = (k < 6) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      e1  = (k >= 1 && k < 7) ? (((k - 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      e2  = (k >= 2 && k < 8) ? (((k - 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      @(negedge clk);
      checks++; if (gnt1 !== eg || gnt2 !== eg) begin errors++; $display("FAIL alt_gnt cyc=%0d got %b/%b exp %b", k, gnt1, gnt2, eg); end
      checks++; if (rv1 !== e1 || rd1 !== (e1 == 2'b01)) begin errors++; $display("FAIL alt_rsp1 cyc=%0d got v=%b d=%b exp v=%b", k, rv1, rd1, e1); end
      checks++; if (rv2 !== e2 || rd2 !== (e2 == 2'b01)) begin errors++; $display("FAIL alt_rsp2 cyc=%0d got v=%b d=%b exp v=%b", k, rv2, rd2, e2); end
      $display("alt cyc=%0d gnt=%b rsp1=%b rsp2=%b", k, gnt1, rv1, rv2);
      step();
    end
  endtask

  task automatic test_frame_squash();
    do_reset();
    req = 2'b01; a0 = 6'h01;
    @(negedge clk);
    checks++; if (gnt2 !== 2'b01) begin errors++; $display("FAIL squash_gnt0 got %b exp 01", gnt2); end
    step();
    req = 2'b10; a1 = 6'h03;
    @(negedge clk);
    checks++; if (gnt2 !== 2'b10) begin errors++; $display("FAIL squash_gnt1 got %b exp 10", gnt2); end
    step();
    req = 2'b00; fs = 1'b1;
    @(negedge clk);
    checks++; if (rv2 !== 2'b00 || rd2 !== 1'b0) begin errors++; $display("FAIL squash_fs got v=%b d=%b exp 00/0", rv2, rd2); end
    step();
    fs = 1'b0;
    @(negedge clk);
    checks++; if (rv2 !== 2'b00) begin errors++; $display("FAIL squash_after got %b exp 00", rv2); end
    step();
    @(negedge clk);
    checks++; if (col2 !== 1'b0) begin errors++; $display("FAIL squash_color got %b exp 0", col2); end
    step();
    $display("test_frame_squash done");
  endtask

  task automatic test_frame_grant();
    do_reset();
    req = 2'b01; a0 = 6'h0B;
    step();
    fs = 1'b1; req = 2'b10;
    @(negedge clk);
    checks++; if (gnt1 !== 2'b00 || en1 !== 1'b0) begin errors++; $display("FAIL fs_block got gnt=%b en=%b exp 00/0", gnt1, en1); end
    step();
    fs = 1'b0; req = 2'b11;
    @(negedge clk);
    checks++; if (gnt1 !== 2'b01) begin errors++; $display("FAIL fs_ptr_reset got %b exp 01", gnt1); end
    step();
    req = 2'b10;
    @(negedge clk);
    checks++; if (gnt1 !== 2'b10) begin errors++; $display("FAIL fs_req10 got %b exp 10", gnt1); end
    step();
    req = 2'b01;
    step();
    fs = 1'b1; req = 2'b11;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (gnt1 !== 2'b00) begin errors++; $display("FAIL fs_consec cyc=%0d got %b exp 00", k, gnt1); end
      step();
    end
    fs = 1'b0;
    @(negedge clk);
    checks++; if (gnt1 !== 2'b01) begin errors++; $display("FAIL fs_consec_ptr got %b exp 01", gnt1); end
    step();
    req = 2'b00;
    $display("test_frame_grant done");
  endtask

  task automatic test_color();
    do_reset();
    req = 2'b01; a0 = 6'h01;
    step();
    req = 2'b10; a1 = 6'h02;
    @(negedge clk);
    checks++; if (rv1 !== 2'b01 || rd1 !== 1'b1) begin errors++; $display("FAIL color_rsp0 got v=%b d=%b exp 01/1", rv1, rd1); end
    step();
    req = 2'b00;
    @(negedge clk);
    checks++; if (rv1 !== 2'b10 || rd1 !== 1'b0) begin errors++; $display("FAIL color_rsp1 got v=%b d=%b exp 10/0", rv1, rd1); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (col1 !== 1'b1) begin errors++; $display("FAIL color_hold cyc=%0d got %b exp 1", k, col1); end
      step();
    end
    fs = 1'b1;
    @(negedge clk);
    checks++; if (col1 !== 1'b1) begin errors++; $display("FAIL color_fs_cycle got %b exp 1", col1); end
    step();
    fs = 1'b0;
    @(negedge clk);
    checks++; if (col1 !== 1'b0) begin errors++; $display("FAIL color_cleared got %b exp 0", col1); end
    step();
    $display("test_color done");
  endtask

  task automatic test_reset_midread();
    req = 2'b01; a0 = 6'h01; fs = 1'b0;
    @(negedge clk);
    checks++; if (gnt2 !== 2'b01 || gnt1 !== 2'b01) begin errors++; $display("FAIL mid_gnt got %b/%b exp 01", gnt1, gnt2); end
    step();
    rst_n = 1'b0; req = 2'b11;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if ({gnt1, en1, addr1, rv1, rd1, col1} !== '0) begin errors++; $display("FAIL mid_rst1 cyc=%0d got %b exp 0", k, {gnt1, en1, addr1, rv1, rd1, col1}); end
      checks++; if ({gnt2, en2, addr2, rv2, rd2, col2} !== '0) begin errors++; $display("FAIL mid_rst2 cyc=%0d got %b exp 0", k, {gnt2, en2, addr2, rv2, rd2, col2}); end
      step();
    end
    rst_n = 1'b1; req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (rv1 !== 2'b00 || rv2 !== 2'b00) begin errors++; $display("FAIL mid_norsp cyc=%0d got %b/%b exp 00", k, rv1, rv2); end
      step();
    end
    req = 2'b11;
    @(negedge clk);
    checks++; if (gnt1 !== 2'b01 || gnt2 !== 2'b01) begin errors++; $display("FAIL mid_resume got %b/%b exp 01", gnt1, gnt2); end
    step();
    req = 2'b00;
    $display("test_reset_midread done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fs = 1'b0; req = 2'b00; a0 = '0; a1 = '0;
    test_reset();
    test_single();
    test_alternate();
    test_frame_squash();
    test_frame_grant();
    test_color();
    test_reset_midread();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
